// File: rtl/ifu_pkg.sv
// Shared defaults and FSM encoding for the instruction fetch unit.
package ifu_pkg;
  localparam int          IFU_ADDR_WIDTH = 32;
  localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;
  localparam int          IFU_PC_STEP    = 4;

  typedef enum logic {
    IFU_IDLE = 1'b0,
    IFU_RUN  = 1'b1
  } ifu_state_e;
endpackage

// File: rtl/ifu_if.sv
// Fetch-address bus between the IFU (master) and its downstream consumer (slave).
interface ifu_if
  import ifu_pkg::*;
#(
  parameter int ADDR_WIDTH = IFU_ADDR_WIDTH
);
  logic                  ready;
  logic                  valid;
  logic                  jmp_en;
  logic [ADDR_WIDTH-1:0] jmp_pc;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_next;

  modport master (input  ready, jmp_en, jmp_pc, output valid, pc, pc_next);
  modport slave  (output ready, jmp_en, jmp_pc, input  valid, pc, pc_next);
endinterface

// File: rtl/ifu_pc_reg.sv
// Fetch PC register: async reset to the boot address, loads only when enabled.
module ifu_pc_reg #(
  parameter int                  ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] d_i,
  output logic [ADDR_WIDTH-1:0] q_o
);
  logic [ADDR_WIDTH-1:0] pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pc_q <= RESET_VAL;
    else if (en_i) pc_q <= d_i;
  end

  assign q_o = pc_q;
endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: sequential/redirect next-PC selection with a valid/ready
// handshake. Valid comes straight from the state register.
module ifu
  import ifu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = IFU_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(IFU_RESET_PC),
  parameter int                    PC_STEP    = IFU_PC_STEP
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_sys_ready,
  output logic                  o_sys_valid,
  input  logic                  i_exu_jmp_en,
  input  logic [ADDR_WIDTH-1:0] i_exu_jmp_pc,
  output logic [ADDR_WIDTH-1:0] o_ifu_pc,
  output logic [ADDR_WIDTH-1:0] o_ifu_pc_next
);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  ifu_state_e state_q, state_d;
  logic       xfer;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) state_q <= IFU_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IFU_IDLE: state_d = IFU_RUN;
      IFU_RUN:  state_d = IFU_RUN;
      default:  state_d = IFU_IDLE;
    endcase
  end

  assign o_sys_valid = (state_q == IFU_RUN);
  assign xfer        = o_sys_valid & i_sys_ready;

  // Redirect wins over the sequential step; low target bits are dropped, not trapped.
  assign o_ifu_pc_next = i_exu_jmp_en ? (i_exu_jmp_pc & ALIGN_MASK)
                                      : o_ifu_pc + ADDR_WIDTH'(PC_STEP);

  ifu_pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_VAL  (RESET_PC)
  ) u_pc_reg (
    .clk  (i_sys_clk),
    .rst  (i_sys_rst),
    .en_i (xfer),
    .d_i  (o_ifu_pc_next),
    .q_o  (o_ifu_pc)
  );
endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios followed by random traffic
// against a transfer-level PC model.
module tb_ifu;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifu_if #(.ADDR_WIDTH(32)) bus ();

  ifu dut (
    .i_sys_clk     (clk),
    .i_sys_rst     (rst),
    .i_sys_ready   (bus.ready),
    .o_sys_valid   (bus.valid),
    .i_exu_jmp_en  (bus.jmp_en),
    .i_exu_jmp_pc  (bus.jmp_pc),
    .o_ifu_pc      (bus.pc),
    .o_ifu_pc_next (bus.pc_next)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_pc     = RST_PC;
  logic        m_valid  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_next();
    if (bus.jmp_en) return {bus.jmp_pc[31:2], 2'b00};
    return m_pc + 32'd4;
  endfunction

  task automatic edge_();
    @(posedge clk);
    if (!rst) begin
      if (m_valid && bus.ready) m_pc = m_next();
      m_valid = 1'b1;
    end
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_pc"},    bus.pc,            m_pc);
    chk({tag, "_valid"}, 32'(bus.valid),    32'(m_valid));
    chk({tag, "_next"},  bus.pc_next,       m_next());
  endtask

  task automatic set_in(input logic rdy, input logic je, input logic [31:0] jp);
    bus.ready  = rdy;
    bus.jmp_en = je;
    bus.jmp_pc = jp;
    #1;
  endtask

  initial begin
    bus.ready = 1'b0; bus.jmp_en = 1'b0; bus.jmp_pc = '0;

    // reset held for a cycle
    #3;
    edge_();
    check_state("rst");
    chk("rst_pc_const", bus.pc, 32'h8000_0000);
    chk("rst_valid_const", 32'(bus.valid), 32'd0);
    rst = 1'b0;
    edge_();
    chk("post_rst_valid", 32'(bus.valid), 32'd1);
    check_state("post_rst");

    // sequential
    set_in(1'b1, 1'b0, '0);
    for (int k = 0; k < 5; k++) begin
      chk("seq_pc", bus.pc, RST_PC + 32'(4 * k));
      check_state("seq");
      edge_();
    end

    // held jump
    set_in(1'b1, 1'b1, 32'h9000_0000);
    chk("jmp_next_imm", bus.pc_next, 32'h9000_0000);
    for (int k = 0; k < 5; k++) begin
      edge_();
      chk("jmp_hold", bus.pc, 32'h9000_0000);
      check_state("jmp");
    end
    set_in(1'b1, 1'b0, '0);
    edge_();
    chk("jmp_seq1", bus.pc, 32'h9000_0004);
    edge_();
    chk("jmp_seq2", bus.pc, 32'h9000_0008);

    // async reset between edges
    set_in(1'b0, 1'b0, '0);
    #1 rst = 1'b1;
    m_pc = RST_PC; m_valid = 1'b0;
    #1;
    chk("midrst_pc", bus.pc, 32'h8000_0000);
    chk("midrst_valid", 32'(bus.valid), 32'd0);
    edge_();
    rst = 1'b0;
    edge_();
    set_in(1'b1, 1'b0, '0);
    edge_();
    edge_();
    chk("stall_start", bus.pc, 32'h8000_0008);

    // stall with a jump that drops before ready returns
    set_in(1'b0, 1'b1, 32'h1234_5678);
    edge_();
    set_in(1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      chk("stall_pc", bus.pc, 32'h8000_0008);
      chk("stall_next", bus.pc_next, 32'h8000_000C);
      edge_();
    end
    set_in(1'b1, 1'b0, '0);
    edge_();
    chk("stall_resume", bus.pc, 32'h8000_000C);

    // alignment and wrap
    set_in(1'b1, 1'b1, 32'hFFFF_FFFF);
    chk("align_next", bus.pc_next, 32'hFFFF_FFFC);
    edge_();
    chk("align_pc", bus.pc, 32'hFFFF_FFFC);
    set_in(1'b1, 1'b0, '0);
    edge_();
    chk("wrap_pc", bus.pc, 32'h0000_0000);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (rst) rst = ($urandom_range(1) == 0) ? 1'b0 : 1'b1;
      else     rst = ($urandom_range(39) == 0);
      if (rst) begin m_pc = RST_PC; m_valid = 1'b0; end
      bus.ready  = ($urandom_range(3) != 0);
      bus.jmp_en = ($urandom_range(4) == 0);
      bus.jmp_pc = $urandom;
      if ($urandom_range(7) == 0) bus.jmp_pc = 32'hFFFF_FFFF;
      #1;
      check_state("rnd");
      edge_();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1);
  end
endmodule
